// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Optional build macro: IMEM_WRITE_PROTECT_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  // Word-aligned and inside the array, using every upper address bit.
  function automatic logic addr_ok(
    input logic [63:0] addr,
    input logic [63:0] depth
  );
    return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one sync write port, one registered read port.
// Reset refills every word with FILL.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int IW = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] FILL = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= FILL;
      end
      rdata <= FILL;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loadable instruction memory: valid/ready load stream, 1-cycle fetch.
// Optional build macro: IMEM_WRITE_PROTECT_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_valid,
  output logic [DATA_W-1:0]          fetch_instr,
  output logic                       fetch_fault,
  output logic                       loaded,
  output logic [$clog2(DEPTH+1)-1:0] load_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     wptr;
  logic              accept;
  logic              restart;
  logic              beat_end;
  logic              fault;
  logic              fault_q;
  logic [DATA_W-1:0] rdata;

`ifdef IMEM_WRITE_PROTECT_EN
  assign load_ready = (state != READY);
  assign restart    = 1'b0;
`else
  assign load_ready = 1'b1;
  assign restart    = (state == READY);
`endif

  assign accept   = load_valid && load_ready;
  assign wptr     = restart ? '0 : ptr;
  assign beat_end = load_last || (wptr == IW'(DEPTH-1));

  assign fault = (state != READY)
              || !addr_ok(64'(fetch_addr), 64'(DEPTH));

  assign loaded      = (state == READY);
  assign fetch_fault = fault_q;
  assign fetch_instr = fault_q ? NOP_WORD : rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      ptr         <= '0;
      load_count  <= '0;
      fetch_valid <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      if (accept) begin
        ptr   <= wptr + IW'(1);
        state <= beat_end ? READY : LOADING;
        if (restart) begin
          load_count <= CW'(1);
        end else if (load_count != CW'(DEPTH)) begin
          load_count <= load_count + CW'(1);
        end
      end
      fetch_valid <= fetch_req;
      if (fetch_req) begin
        fault_q <= fault;
      end
    end
  end

  imem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IW    (IW),
    .FILL  (NOP_WORD)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (accept),
    .waddr(wptr),
    .wdata(load_data),
    .re   (fetch_req),
    .raddr(fetch_addr[IW+1:2]),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (DEPTH=32): vector table plus sequences.
// Expectations follow IMEM_WRITE_PROTECT_EN when it is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        loaded;
  logic [5:0]  load_count;

`ifdef IMEM_WRITE_PROTECT_EN
  localparam logic RR = 1'b0;
`else
  localparam logic RR = 1'b1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .DATA_W(32),
    .DEPTH (32),
    .ADDR_W(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault),
    .loaded     (loaded),
    .load_count (load_count)
  );

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic        fr;
    logic [31:0] fa;
    logic        ev;
    logic [31:0] ei;
    logic        ef;
    logic        el;
    logic [5:0]  ec;
    logic        er;
  } vec_t;

  vec_t tbl [13];

  task automatic expect_out(
    input string       nm,
    input logic        ev,
    input logic [31:0] ei,
    input logic        ef,
    input logic        el,
    input logic [5:0]  ec,
    input logic        er
  );
    n_vec++;
    if ({fetch_valid, fetch_instr, fetch_fault, loaded, load_count, load_ready}
        !== {ev, ei, ef, el, ec, er}) begin
      n_bad++;
      $display("FAIL %s: got v=%0b i=%h f=%0b l=%0b c=%0d r=%0b want v=%0b i=%h f=%0b l=%0b c=%0d r=%0b",
               nm, fetch_valid, fetch_instr, fetch_fault, loaded, load_count,
               load_ready, ev, ei, ef, el, ec, er);
    end
  endtask

  task automatic drive(
    input logic        lv,
    input logic [31:0] ld,
    input logic        ll,
    input logic        fr,
    input logic [31:0] fa
  );
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    fetch_req  = fr;
    fetch_addr = fa;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    fetch_req  = 1'b0;
  endtask

  task automatic do_reset(input logic lv, input logic fr);
    reset = 1'b1;
    drive(lv, 32'hDEAD_0000, 1'b0, fr, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0, 32'h0, 0, 1, 32'h00, 1, NOP, 1, 0, 0, 1};
    tbl[1]  = '{1, 32'h00A00213, 0, 0, 32'h0, 0, NOP, 1, 0, 1, 1};
    tbl[2]  = '{1, 32'h02020E63, 0, 0, 32'h0, 0, NOP, 1, 0, 2, 1};
    tbl[3]  = '{1, 32'hFFF20213, 1, 1, 32'h08, 1, NOP, 1, 1, 3, RR};
    tbl[4]  = '{0, 32'h0, 0, 1, 32'h00, 1, 32'h00A00213, 0, 1, 3, RR};
    tbl[5]  = '{0, 32'h0, 0, 1, 32'h04, 1, 32'h02020E63, 0, 1, 3, RR};
    tbl[6]  = '{0, 32'h0, 0, 1, 32'h08, 1, 32'hFFF20213, 0, 1, 3, RR};
    tbl[7]  = '{0, 32'h0, 0, 1, 32'h0C, 1, NOP, 0, 1, 3, RR};
    tbl[8]  = '{0, 32'h0, 0, 1, 32'h02, 1, NOP, 1, 1, 3, RR};
    tbl[9]  = '{0, 32'h0, 0, 1, 32'h80, 1, NOP, 1, 1, 3, RR};
    tbl[10] = '{0, 32'h0, 0, 0, 32'h00, 0, NOP, 1, 1, 3, RR};
    tbl[11] = '{0, 32'h0, 0, 1, 32'h8000_0000, 1, NOP, 1, 1, 3, RR};
    tbl[12] = '{0, 32'h0, 0, 1, 32'h7C, 1, NOP, 0, 1, 3, RR};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    do_reset(1'b0, 1'b0);
    expect_out("reset", 0, NOP, 0, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].lv, tbl[i].ld, tbl[i].ll, tbl[i].fr, tbl[i].fa);
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei,
                 tbl[i].ef, tbl[i].el, tbl[i].ec, tbl[i].er);
    end

    // Overflow guard: 32 beats without last must complete the image.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 32'h1000 + i, 1'b0, 1'b0, 32'h0);
      expect_out($sformatf("stream%0d", i), 0, NOP, 0, (i == 31),
                 6'(i + 1), (i == 31) ? RR : 1'b1);
    end

`ifdef IMEM_WRITE_PROTECT_EN
    drive(1'b1, 32'hBEEF, 1'b0, 1'b1, 32'h0);
    expect_out("beat33_ignored", 1, 32'h1000, 0, 1, 32, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    expect_out("wp_word1", 1, 32'h1001, 0, 1, 32, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
    expect_out("wp_word2", 1, 32'h1002, 0, 1, 32, 0);
`else
    drive(1'b1, 32'hBEEF, 1'b0, 1'b1, 32'h0);
    expect_out("beat33_restart", 1, 32'h1000, 0, 0, 1, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    expect_out("reload_fault", 1, NOP, 1, 0, 1, 1);
    drive(1'b1, 32'hCAFE, 1'b1, 1'b0, 32'h0);
    expect_out("reload_last", 0, NOP, 1, 1, 2, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    expect_out("new_word0", 1, 32'hBEEF, 0, 1, 2, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    expect_out("new_word1", 1, 32'hCAFE, 0, 1, 2, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
    expect_out("old_word2", 1, 32'h1002, 0, 1, 2, 1);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h7C);
    expect_out("word31", 1, 32'h101F, 0, 1, RR ? 6'd2 : 6'd32, RR);

    // Reset in the middle of a load, with a fetch in the same cycle.
    do_reset(1'b0, 1'b0);
    drive(1'b1, 32'hAAAA, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'hBBBB, 1'b0, 1'b0, 32'h0);
    expect_out("midload", 0, NOP, 0, 0, 2, 1);
    reset = 1'b1;
    drive(1'b1, 32'hCCCC, 1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    expect_out("reset_wins", 0, NOP, 0, 0, 0, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    expect_out("post_reset_fault", 1, NOP, 1, 0, 0, 1);
    drive(1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0);
    expect_out("single_load", 0, NOP, 1, 1, 1, RR);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    expect_out("single_word0", 1, 32'h12345678, 0, 1, 1, RR);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    expect_out("refilled_word1", 1, NOP, 0, 1, 1, RR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, loadable instruction memory for the single-cycle RISC-V core. It replaces the reset-initialised fixed program store with a storage array that is filled at runtime through a valid/ready load stream. Instruction fetch goes through a registered, one-cycle request/response port that flags fault conditions. It sits between the boot/host interface and the core's fetch stage.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- DEPTH, 32, number of words; power of two, ≥ 2
- ADDR_W, 32, byte-address width of fetch_addr
- NOP_WORD, 32'h0000_0013, fill/response word (ADDI x0,x0,0)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load beat present
- load_ready  out  1  block accepts a load beat
- load_data  in  DATA_W  instruction word to store
- load_last  in  1  final beat of the image
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  byte address (word index = fetch_addr[ADDR_W-1:2])
- fetch_valid  out  1  response valid, one cycle after fetch_req
- fetch_instr  out  DATA_W  fetched word
- fetch_fault  out  1  response is faulted; fetch_instr = NOP_WORD
- loaded  out  1  image complete (state READY)
- load_count  out  $clog2(DEPTH+1)  words written in current image

## Operation
- States: EMPTY, LOADING, READY.
- Reset: state → EMPTY; all DEPTH words ← NOP_WORD; write pointer and load_count ← 0.
- Reset output values: load_ready=1, fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, loaded=0, load_count=0.
- A beat is accepted when load_valid && load_ready.
  - The beat writes mem[ptr]; ptr and load_count increment.
- EMPTY → LOADING on the first accepted beat, unless that beat ends the image.
- An accepted beat ends the image, and the state goes to READY, when either:
  - load_last=1, or
  - ptr = DEPTH-1. This is an overflow guard; further beats never wrap.
- load_ready:
  - 1 in EMPTY and LOADING.
  - In READY it depends on the configuration (see below).
- Fetch:
  - A fetch_req at edge N produces fetch_valid=1 at N+1 with the response.
  - With no fetch_req, fetch_valid=0 and fetch_instr/fetch_fault hold their values.
- fault = any of the following, evaluated at the request edge:
  - state ≠ READY
  - fetch_addr[1:0] ≠ 0
  - word index ≥ DEPTH
- Faulted response: fetch_instr=NOP_WORD, fetch_fault=1. Otherwise fetch_instr=mem[index], fetch_fault=0.
- loaded = (state == READY).

## Timing
- Fetch latency: exactly 1 cycle. fetch_req may be asserted every cycle, giving a fully pipelined response stream.
- Load throughput: one word per cycle.
- Simultaneous final load beat and fetch_req in the same cycle: the fetch sees pre-edge state LOADING and is faulted. The first successful fetch is possible in the cycle after loaded rises.
- Simultaneous load write and fetch of the same index: the fetch returns the old content.
- Reset mid-load or mid-fetch: reset wins.
  - The pending fetch response is dropped: fetch_valid=0 next cycle.
  - Memory is refilled with NOP_WORD.
- Width rule: load_count saturates at DEPTH. The index compare uses the full upper address bits, with no truncation aliasing.

## Configuration
- IMEM_WRITE_PROTECT_EN defined:
  - In READY, load_ready=0 until reset.
  - load_valid is ignored; the image is immutable.
- Not defined:
  - In READY, load_ready=1.
  - An accepted beat starts a new image: it writes word 0, sets load_count=1, and moves to LOADING (or READY if the beat ends the image).
  - loaded drops in the cycle after the beat.
  - Words beyond the new image keep their old contents.

## Structure
- Package imem_pkg holds:
  - state enum (EMPTY, LOADING, READY)
  - NOP_WORD default constant
  - helper function for the word-index/range check
- Sub-module imem_array:
  - DEPTH×DATA_W storage
  - one synchronous write port
  - one registered read port
  - synchronous clear-to-fill on reset
- The FSM, pointer and fault logic live in imem_loader.

## Test plan
- Reset, then fetch at 0x0 → next cycle fetch_valid=1, fetch_fault=1, fetch_instr=0x00000013, loaded=0.
- Load 3 words (0x00A00213, 0x02020E63, 0xFFF20213), last on the 3rd → loaded=1, load_count=3.
  - Back-to-back fetches at 0x0, 0x4, 0x8, 0xC return those three words, then 0x00000013, each with 1-cycle latency and fault=0.
- After load, fetch 0x2 → fault=1. Fetch 0x80 (DEPTH=32) → fault=1, fetch_instr=NOP.
- Stream 33 beats with load_last=0 → READY after the 32nd beat, load_count=32.
  - 33rd beat: load_ready=0 with the macro defined; restarts at word 0 without it.
- Assert reset after 2 of 5 beats → load_count=0, loaded=0, fetch at 0x0 faulted.
  - Reload 1 word 0x12345678 with last=1 → fetch 0x0 returns 0x12345678.
- Final load beat and fetch_req in the same cycle → that response is faulted; a fetch in the next cycle succeeds.
